mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//   Parametrised MEM->WB pipeline register for the openMIPS core.
//   Carries the GPR, HI/LO and LLbit write-back fields with a valid bit.
//   Supports the stall vector from the ctrl unit, exception flush and bubble insertion.
//   Keeps a free-running retired-instruction counter for debug/perf use.
// PARAMETERS
//   DATA_W   32  width of GPR/HI/LO data fields
//   REG_AW   5   width of GPR destination address
//   STALL_W  6   width of the ctrl stall vector
//   MEM_IDX  4   stall-vector bit owned by the MEM stage
//   WB_IDX   5   stall-vector bit owned by the WB stage
//   CNT_W    32  width of retire_cnt
// PORTS
//   clk             in   1        clock, rising edge
//   rst             in   1        synchronous reset, active-high
//   flush           in   1        exception flush, kills the instruction entering WB
//   stall           in   STALL_W  ctrl stall vector, bit i=1 holds stage i
//   mem_valid       in   1        MEM holds a real instruction
//   mem_wd          in   REG_AW   GPR destination address
//   mem_wreg        in   1        GPR write enable
//   mem_wdata       in   DATA_W   GPR write data
//   mem_whilo       in   1        HI/LO write enable
//   mem_hi          in   DATA_W   HI write data
//   mem_lo          in   DATA_W   LO write data
//   mem_llbit_we    in   1        LLbit write enable
//   mem_llbit_value in   1        LLbit write value
//   wb_valid        out  1        WB holds a real instruction
//   wb_wd, wb_wreg, wb_wdata           out  REG_AW/1/DATA_W  registered GPR fields
//   wb_whilo, wb_hi, wb_lo             out  1/DATA_W/DATA_W  registered HI/LO fields
//   wb_llbit_we, wb_llbit_value        out  1/1              registered LLbit fields
//   retire_cnt      out  CNT_W    count of instructions that have entered WB
// BEHAVIOUR
//   - All outputs are registered and update on posedge clk only.
//   - Latency is 1 cycle, MEM to WB.
//   - Per-cycle action, in priority order (first match wins):
//     1 rst=1: RESET.
//       - All wb_* = 0; wb_wd = NOPRegAddr (0); retire_cnt = 0.
//     2 flush=1: BUBBLE.
//       - Flush overrides any stall.
//     3 stall[MEM_IDX]=1, stall[WB_IDX]=0: BUBBLE.
//       - MEM is stalled while WB drains.
//     4 stall[MEM_IDX]=1, stall[WB_IDX]=1: HOLD.
//       - All wb_* and retire_cnt keep their values.
//     5 stall[MEM_IDX]=0, stall[WB_IDX]=1: illegal from ctrl; HOLD.
//     6 otherwise: ADVANCE.
//       - wb_* take the corresponding mem_*.
//       - retire_cnt += 1 if mem_valid=1.
//   - BUBBLE: wb_valid, wb_wreg, wb_whilo and wb_llbit_we = 0.
//     - Data and address fields = 0; retire_cnt unchanged.
//   - ADVANCE with mem_valid=0: the fields are still copied.
//     - Enables are forced to 0, so no write-back can occur from an invalid slot.
//   - retire_cnt wraps modulo 2^CNT_W with no saturation; flush never clears it.
//   - Stall bits other than MEM_IDX and WB_IDX are ignored.
//   - Reset mid-stall or mid-flush: reset wins; the next cycle proceeds normally.
// TESTING
//   T1 rst=1 for 2 cycles -> all wb_* = 0, retire_cnt = 0.
//   T2 ADVANCE: mem_valid=1, wd=5'd3, wreg=1, wdata=32'hDEADBEEF.
//      -> next cycle wb_wd=3, wb_wreg=1, wb_wdata=DEADBEEF, retire_cnt=1.
//   T3 stall=6'b110000 for 3 cycles after T2 -> wb_* hold DEADBEEF state; retire_cnt stays 1.
//   T4 stall=6'b011111 with mem_wreg=1 -> wb_valid=0, wb_wreg=0, wb_wdata=0; retire_cnt unchanged.
//   T5 flush=1 with stall=6'b111111 and mem_whilo=1, hi=1, lo=2.
//      -> wb_whilo=0, wb_hi=0, wb_lo=0, wb_valid=0.
//   T6 preload retire_cnt to 2^CNT_W-1 via a run of advances (CNT_W=4 build), then one valid advance.
//      -> retire_cnt=0; mem_valid=0 advance with wreg=1 -> wb_wreg=0.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
//   MEM->WB pipeline register for the openMIPS core. Carries the GPR,
//   HI/LO and LLbit write-back fields plus a valid bit, honours the ctrl
//   stall vector, exception flush and bubble insertion, and keeps a
//   free-running count of instructions that have entered WB.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   flush               exception flush; kills the instruction entering WB
//   stall[STALL_W]      ctrl stall vector, bit i=1 holds stage i
//   mem_*               write-back fields presented by the MEM stage
//   wb_*                registered write-back fields seen by WB
//   retire_cnt[CNT_W]   instructions that have entered WB (wraps)
//
// Per-cycle priority: reset, flush (bubble), MEM stalled with WB free
// (bubble), WB stalled (hold), otherwise advance.
module mem_wb_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int STALL_W = 6,
    parameter int MEM_IDX = 4,
    parameter int WB_IDX  = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               mem_valid,
    input  logic [REG_AW-1:0]  mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    input  logic               mem_llbit_we,
    input  logic               mem_llbit_value,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic               wb_llbit_we,
    output logic               wb_llbit_value,
    output logic [CNT_W-1:0]   retire_cnt
);

    // NOP register address written into wb_wd on reset/bubble
    localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;

    logic w_mem_stall;
    logic w_wb_stall;
    logic w_bubble;
    logic w_hold;

    logic               r_valid;
    logic [REG_AW-1:0]  r_wd;
    logic               r_wreg;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_whilo;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic               r_llbit_we;
    logic               r_llbit_value;
    logic [CNT_W-1:0]   r_retire_cnt;

    assign w_mem_stall = stall[MEM_IDX];
    assign w_wb_stall  = stall[WB_IDX];

    // Flush beats any stall. A WB stall without a MEM stall is illegal from
    // ctrl but is treated as a hold so WB is never overwritten while stalled.
    assign w_bubble = flush | (w_mem_stall & ~w_wb_stall);
    assign w_hold   = ~flush & w_wb_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_wd          <= NOP_REG_ADDR;
            r_wreg        <= 1'b0;
            r_wdata       <= '0;
            r_whilo       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_llbit_we    <= 1'b0;
            r_llbit_value <= 1'b0;
            r_retire_cnt  <= '0;
        end else if (w_bubble) begin
            // retire_cnt deliberately untouched: a bubble retires nothing
            r_valid       <= 1'b0;
            r_wd          <= NOP_REG_ADDR;
            r_wreg        <= 1'b0;
            r_wdata       <= '0;
            r_whilo       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_llbit_we    <= 1'b0;
            r_llbit_value <= 1'b0;
        end else if (!w_hold) begin
            // Fields copy through even for an invalid slot; only the write
            // enables are gated so nothing is written back from it.
            r_valid       <= mem_valid;
            r_wd          <= mem_wd;
            r_wreg        <= mem_wreg & mem_valid;
            r_wdata       <= mem_wdata;
            r_whilo       <= mem_whilo & mem_valid;
            r_hi          <= mem_hi;
            r_lo          <= mem_lo;
            r_llbit_we    <= mem_llbit_we & mem_valid;
            r_llbit_value <= mem_llbit_value;
            if (mem_valid) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
        end
    end

    assign wb_valid       = r_valid;
    assign wb_wd          = r_wd;
    assign wb_wreg        = r_wreg;
    assign wb_wdata       = r_wdata;
    assign wb_whilo       = r_whilo;
    assign wb_hi          = r_hi;
    assign wb_lo          = r_lo;
    assign wb_llbit_we    = r_llbit_we;
    assign wb_llbit_value = r_llbit_value;
    assign retire_cnt     = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe
//   Self-checking bench for mem_wb_pipe (CNT_W=4 build so the retire
//   counter wrap is reachable). Each step pushes the expected WB state
//   onto a queue before the clock edge; tasks pop and compare after it.
module tb_mem_wb_pipe;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int STALL_W = 6;
    localparam int CNT_W   = 4;
    localparam int VW = 1 + REG_AW + 1 + DATA_W + 1 + DATA_W + DATA_W + 1 + 1 + CNT_W;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               flush;
    logic [STALL_W-1:0] stall;
    logic               mem_valid;
    logic [REG_AW-1:0]  mem_wd;
    logic               mem_wreg;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_whilo;
    logic [DATA_W-1:0]  mem_hi;
    logic [DATA_W-1:0]  mem_lo;
    logic               mem_llbit_we;
    logic               mem_llbit_value;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_wd;
    logic               wb_wreg;
    logic [DATA_W-1:0]  wb_wdata;
    logic               wb_whilo;
    logic [DATA_W-1:0]  wb_hi;
    logic [DATA_W-1:0]  wb_lo;
    logic               wb_llbit_we;
    logic               wb_llbit_value;
    logic [CNT_W-1:0]   retire_cnt;

    mem_wb_pipe #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .STALL_W(STALL_W),
        .MEM_IDX(4),
        .WB_IDX (5),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .stall          (stall),
        .mem_valid      (mem_valid),
        .mem_wd         (mem_wd),
        .mem_wreg       (mem_wreg),
        .mem_wdata      (mem_wdata),
        .mem_whilo      (mem_whilo),
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_llbit_we   (mem_llbit_we),
        .mem_llbit_value(mem_llbit_value),
        .wb_valid       (wb_valid),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .wb_whilo       (wb_whilo),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_llbit_we    (wb_llbit_we),
        .wb_llbit_value (wb_llbit_value),
        .retire_cnt     (retire_cnt)
    );

    // scoreboard
    logic [VW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic               m_valid = 1'b0;
    logic [REG_AW-1:0]  m_wd    = '0;
    logic               m_wreg  = 1'b0;
    logic [DATA_W-1:0]  m_wdata = '0;
    logic               m_whilo = 1'b0;
    logic [DATA_W-1:0]  m_hi    = '0;
    logic [DATA_W-1:0]  m_lo    = '0;
    logic               m_llwe  = 1'b0;
    logic               m_llv   = 1'b0;
    logic [CNT_W-1:0]   m_cnt   = '0;

    function automatic logic [VW-1:0] dut_vec();
        return {wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
                wb_llbit_we, wb_llbit_value, retire_cnt};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_valid, m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo,
                m_llwe, m_llv, m_cnt};
    endfunction

    task automatic model_zero_fields();
        m_valid = 1'b0; m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
        m_whilo = 1'b0; m_hi = '0; m_lo = '0; m_llwe = 1'b0; m_llv = 1'b0;
    endtask

    // driver: apply one cycle of inputs, push the expected post-edge state,
    // then advance to 1 time unit after the rising edge
    task automatic step(input logic r, input logic f, input logic [STALL_W-1:0] s,
                        input logic v, input logic [REG_AW-1:0] wd, input logic wr,
                        input logic [DATA_W-1:0] wdat, input logic whl,
                        input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                        input logic llwe, input logic llv);
        rst = r; flush = f; stall = s;
        mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
        mem_whilo = whl; mem_hi = hi; mem_lo = lo;
        mem_llbit_we = llwe; mem_llbit_value = llv;
        if (r) begin
            model_zero_fields();
            m_cnt = '0;
        end else if (f || (s[4] && !s[5])) begin
            model_zero_fields();
        end else if (!s[5]) begin
            m_valid = v; m_wd = wd; m_wreg = wr & v; m_wdata = wdat;
            m_whilo = whl & v; m_hi = hi; m_lo = lo;
            m_llwe = llwe & v; m_llv = llv;
            if (v) m_cnt = m_cnt + 1'b1;
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 6'h00, 1'b1, 5'd9, 1'b1, 32'h12345678, 1'b1,
                 32'h1, 32'h2, 1'b1, 1'b1);
            exp = exp_q.pop_front();
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL reset_%0d: got=%h exp=%h", i, dut_vec(), exp);
            end
        end
        n_checks++;
        if (retire_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got=%0d exp=0", retire_cnt);
        end
    endtask

    task automatic test_advance();
        logic [VW-1:0] exp;
        step(1'b0, 1'b0, 6'h00, 1'b1, 5'd3, 1'b1, 32'hDEADBEEF, 1'b0,
             32'h0, 32'h0, 1'b0, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL advance: got=%h exp=%h", dut_vec(), exp);
        end
        n_checks++;
        if ({wb_wd, wb_wreg, wb_wdata, retire_cnt} !== {5'd3, 1'b1, 32'hDEADBEEF, 4'd1}) begin
            n_fail++;
            $display("FAIL advance_fields: got wd=%0d wreg=%b wdata=%h cnt=%0d exp 3 1 deadbeef 1",
                     wb_wd, wb_wreg, wb_wdata, retire_cnt);
        end
    endtask

    task automatic test_stall_hold();
        logic [VW-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 6'b110000, 1'b1, 5'(i + 10), 1'b1, $urandom(), 1'b1,
                 $urandom(), $urandom(), 1'b1, 1'b1);
            exp = exp_q.pop_front();
            n_checks++;
            if (dut_vec() !== exp || wb_wdata !== 32'hDEADBEEF || retire_cnt !== 4'd1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got=%h exp=%h", i, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_bubble();
        logic [VW-1:0] exp;
        logic [CNT_W-1:0] cnt_before;
        cnt_before = retire_cnt;
        step(1'b0, 1'b0, 6'b011111, 1'b1, 5'd7, 1'b1, 32'hCAFEF00D, 1'b1,
             32'h5, 32'h6, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || wb_valid !== 1'b0 || wb_wreg !== 1'b0 ||
            wb_wdata !== 32'h0 || retire_cnt !== cnt_before) begin
            n_fail++;
            $display("FAIL bubble: got=%h exp=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_flush();
        logic [VW-1:0] exp;
        // load a live instruction first so the flush has something to clear
        step(1'b0, 1'b0, 6'h00, 1'b1, 5'd4, 1'b1, 32'hA5A5A5A5, 1'b1,
             32'h11, 32'h22, 1'b0, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL flush_preload: got=%h exp=%h", dut_vec(), exp);
        end
        step(1'b0, 1'b1, 6'b111111, 1'b1, 5'd8, 1'b1, 32'h77, 1'b1,
             32'h1, 32'h2, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || {wb_whilo, wb_hi, wb_lo, wb_valid} !== '0) begin
            n_fail++;
            $display("FAIL flush: got=%h exp=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_stall_variants();
        logic [VW-1:0] exp;
        // WB-only stall (illegal from ctrl) holds; unrelated stall bits ignored
        step(1'b0, 1'b0, 6'h00, 1'b1, 5'd12, 1'b0, 32'h0BADC0DE, 1'b0,
             32'h3, 32'h4, 1'b1, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL variant_load: got=%h exp=%h", dut_vec(), exp);
        end
        step(1'b0, 1'b0, 6'b100000, 1'b1, 5'd13, 1'b1, 32'h99, 1'b1,
             32'h9, 32'h9, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || wb_wdata !== 32'h0BADC0DE) begin
            n_fail++;
            $display("FAIL wb_only_hold: got=%h exp=%h", dut_vec(), exp);
        end
        step(1'b0, 1'b0, 6'b001111, 1'b1, 5'd14, 1'b1, 32'h55AA55AA, 1'b0,
             32'h0, 32'h0, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || wb_wd !== 5'd14) begin
            n_fail++;
            $display("FAIL ignored_bits: got=%h exp=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_wrap();
        logic [VW-1:0] exp;
        int guard;
        guard = 0;
        while (m_cnt != 4'hF && guard < 32) begin
            step(1'b0, 1'b0, 6'h00, 1'b1, 5'(guard), 1'b1, 32'(guard), 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b0);
            exp = exp_q.pop_front();
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL wrap_preload_%0d: got=%h exp=%h", guard, dut_vec(), exp);
            end
            guard++;
        end
        n_checks++;
        if (retire_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL wrap_max: got=%0d exp=15", retire_cnt);
        end
        step(1'b0, 1'b0, 6'h00, 1'b1, 5'd1, 1'b1, 32'h1, 1'b0,
             32'h0, 32'h0, 1'b0, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || retire_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got=%h exp=%h", dut_vec(), exp);
        end
        step(1'b0, 1'b0, 6'h00, 1'b0, 5'd21, 1'b1, 32'hFEEDFACE, 1'b1,
             32'h7, 32'h8, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || wb_wreg !== 1'b0 || wb_whilo !== 1'b0 ||
            wb_llbit_we !== 1'b0 || wb_wdata !== 32'hFEEDFACE || retire_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL invalid_advance: got=%h exp=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [VW-1:0] exp;
        step(1'b1, 1'b1, 6'b110000, 1'b1, 5'd2, 1'b1, 32'h2, 1'b1,
             32'h2, 32'h2, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || retire_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got=%h exp=%h", dut_vec(), exp);
        end
        step(1'b0, 1'b0, 6'h00, 1'b1, 5'd30, 1'b1, 32'h30303030, 1'b1,
             32'h31, 32'h32, 1'b1, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (dut_vec() !== exp || retire_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL after_reset: got=%h exp=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] exp;
        logic [STALL_W-1:0] s;
        for (int i = 0; i < 300; i++) begin
            s = STALL_W'($urandom());
            if ($urandom_range(0, 1) == 0) s[5:4] = 2'b00;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), s,
                 1'($urandom()), 5'($urandom()), 1'($urandom()), $urandom(),
                 1'($urandom()), $urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
            exp = exp_q.pop_front();
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: got=%h exp=%h", i, dut_vec(), exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0;
        mem_valid = 1'b0; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
        mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
        mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
        test_reset();
        test_advance();
        test_stall_hold();
        test_bubble();
        test_flush();
        test_stall_variants();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
